// File: rtl/panel_load_sequencer_pkg.sv
// Shared types for the front-panel load sequencer: state encoding, word type
// and the default program counter loaded after the last deposit.
package panel_load_sequencer_pkg;

  typedef logic [11:0] word;

  localparam word DEFAULT_START_PC = 12'o0200;

  typedef enum logic [3:0] {
    IDLE,
    GET,
    A_SET,
    A_PUL,
    A_GAP,
    D_SET,
    D_PUL,
    D_GAP,
    P_SET,
    P_PUL,
    P_GAP,
    RUN,
    DONE
  } panel_seq_state_t;

  // States whose duration is governed by the shared delay counter.
  function automatic logic is_timed(panel_seq_state_t s);
    return s inside {A_SET, A_PUL, A_GAP, D_SET, D_PUL, D_GAP, P_SET, P_PUL, P_GAP};
  endfunction

endpackage

// File: rtl/panel_load_sequencer_delay_counter.sv
// Down-counter shared by every timed phase: loaded with N-1 on phase entry,
// reports zero on the last cycle of the phase.
module seq_delay_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/panel_load_sequencer.sv
// Drives the front-panel switches and buttons to deposit a stream of words,
// load the start PC, run the CPU and report when it halts.
module panel_load_sequencer
  import panel_load_sequencer_pkg::*;
#(
  parameter int  SETUP_CYC = 10,
  parameter int  PULSE_CYC = 10,
  parameter int  GAP_CYC   = 30,
  parameter word START_PC  = DEFAULT_START_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [11:0] w_addr,
  input  logic [11:0] w_data,
  input  logic        w_last,
  input  logic        run_led,
  output logic [12:0] sw,
  output logic        load_pc_btn,
  output logic        deposit_btn,
  output logic        busy,
  output logic        done
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  panel_seq_state_t state, next_state;

  word              data_q;
  logic             last_q;
  word              sw_lo;
  logic             run_seen;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  seq_delay_counter #(
    .W(CNT_W)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_value(cnt_value),
    .zero      (cnt_zero)
  );

  // State register plus the latched word and the value presented on sw[11:0];
  // sw[11:0] only changes on entry to a setup phase or on return to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_q   <= '0;
      last_q   <= 1'b0;
      sw_lo    <= '0;
      run_seen <= 1'b0;
    end else begin
      state <= next_state;

      if (state == GET && w_valid) begin
        data_q <= w_data;
        last_q <= w_last;
      end

      if (next_state != state) begin
        case (next_state)
          A_SET:   sw_lo <= w_addr;
          D_SET:   sw_lo <= data_q;
          P_SET:   sw_lo <= START_PC;
          IDLE:    sw_lo <= '0;
          default: ;
        endcase
      end

      // A fall only counts once the CPU has been seen running in this RUN phase.
      if (state != RUN) begin
        run_seen <= 1'b0;
      end else if (run_led) begin
        run_seen <= 1'b1;
      end
    end
  end

  // Next-state, output decode and delay-counter reload on entry to timed phases.
  always_comb begin
    next_state  = state;
    cnt_load    = 1'b0;
    cnt_value   = '0;
    w_ready     = 1'b0;
    load_pc_btn = 1'b0;
    deposit_btn = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    sw          = {1'b0, sw_lo};

    case (state)
      IDLE: if (start) next_state = GET;
      GET: begin
        w_ready = 1'b1;
        if (w_valid) next_state = A_SET;
      end
      A_SET: if (cnt_zero) next_state = A_PUL;
      A_PUL: begin
        load_pc_btn = 1'b1;
        if (cnt_zero) next_state = A_GAP;
      end
      A_GAP: if (cnt_zero) next_state = D_SET;
      D_SET: if (cnt_zero) next_state = D_PUL;
      D_PUL: begin
        deposit_btn = 1'b1;
        if (cnt_zero) next_state = D_GAP;
      end
      D_GAP: if (cnt_zero) next_state = last_q ? P_SET : GET;
      P_SET: if (cnt_zero) next_state = P_PUL;
      P_PUL: begin
        load_pc_btn = 1'b1;
        if (cnt_zero) next_state = P_GAP;
      end
      P_GAP: if (cnt_zero) next_state = RUN;
      RUN: begin
        sw[12] = 1'b1;
        if (run_seen && !run_led) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (next_state != state && is_timed(next_state)) begin
      cnt_load = 1'b1;
      case (next_state)
        A_SET, D_SET, P_SET: cnt_value = SETUP_LD;
        A_PUL, D_PUL, P_PUL: cnt_value = PULSE_LD;
        default:             cnt_value = GAP_LD;
      endcase
    end
  end

endmodule

// File: tb/tb_panel_load_sequencer.sv
// Scoreboard bench for panel_load_sequencer: default-timing instance plus a
// fast instance (SETUP=PULSE=GAP=1) for exact per-word edge timing.
module tb_panel_load_sequencer;

  localparam int SETUP = 10;
  localparam int PULSE = 10;
  localparam int GAP   = 30;
  localparam logic [11:0] PC = 12'o0200;

  typedef struct {
    int          kind;
    logic [11:0] swv;
    int          interval;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic        start, w_valid, w_ready, w_last, run_led;
  logic [11:0] w_addr, w_data;
  logic [12:0] sw;
  logic        load_pc_btn, deposit_btn, busy, done;

  logic        f_start, f_w_valid, f_w_ready, f_w_last, f_run_led;
  logic [11:0] f_w_addr, f_w_data;
  logic [12:0] f_sw;
  logic        f_load_pc_btn, f_deposit_btn, f_busy, f_done;

  int tests  = 0;
  int failed = 0;

  exp_t q[$];
  exp_t fq[$];
  exp_t me, fe;

  always #5 clk = ~clk;

  panel_load_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_ready(w_ready),
    .w_addr(w_addr), .w_data(w_data), .w_last(w_last), .run_led(run_led), .sw(sw),
    .load_pc_btn(load_pc_btn), .deposit_btn(deposit_btn), .busy(busy), .done(done)
  );

  panel_load_sequencer #(.SETUP_CYC(1), .PULSE_CYC(1), .GAP_CYC(1)) dut_fast (
    .clk(clk), .rst(rst), .start(f_start), .w_valid(f_w_valid), .w_ready(f_w_ready),
    .w_addr(f_w_addr), .w_data(f_w_data), .w_last(f_w_last), .run_led(f_run_led), .sw(f_sw),
    .load_pc_btn(f_load_pc_btn), .deposit_btn(f_deposit_btn), .busy(f_busy), .done(f_done)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Default-instance monitor: pops one expectation per button rising edge.
  int cyc = 0, last_rise = 0, rise_cyc = 0, stable = 0;
  int hs_count = 0, last_hs = 0, period_expect = 0;
  logic prev_l = 1'b0, prev_d = 1'b0;
  logic [11:0] prev_sw = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_l  = 1'b0;
      prev_d  = 1'b0;
      prev_sw = sw[11:0];
      stable  = 0;
    end else begin
      if (sw[11:0] != prev_sw) stable = 1; else stable++;
      if (load_pc_btn || deposit_btn) checkOutput("btn_overlap", 32'(load_pc_btn & deposit_btn), 0);
      if ((prev_l || prev_d) && (load_pc_btn || deposit_btn)) checkOutput("sw_hold", 32'(sw[11:0]), 32'(prev_sw));
      if ((load_pc_btn && !prev_l) || (deposit_btn && !prev_d)) begin
        checkOutput("btn_expected", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          me = q.pop_front();
          checkOutput("btn_kind", deposit_btn ? 2 : 1, me.kind);
          checkOutput("btn_sw", 32'(sw[11:0]), 32'(me.swv));
          checkOutput("setup_cycles", stable, SETUP + 1);
          if (me.interval != 0) checkOutput("rise_interval", cyc - last_rise, me.interval);
        end
        last_rise = cyc;
        rise_cyc  = cyc;
      end
      if ((prev_l && !load_pc_btn) || (prev_d && !deposit_btn)) checkOutput("pulse_width", cyc - rise_cyc, PULSE);
      if (w_valid && w_ready) begin
        hs_count++;
        if (period_expect != 0) checkOutput("word_period", cyc - last_hs, period_expect);
        last_hs = cyc;
      end
      prev_l  = load_pc_btn;
      prev_d  = deposit_btn;
      prev_sw = sw[11:0];
    end
  end

  // Fast-instance monitor with 1-cycle phases.
  int f_last_rise = 0, f_rise_cyc = 0, f_stable = 0, f_last_hs = 0, f_period_expect = 0;
  logic f_prev_l = 1'b0, f_prev_d = 1'b0;
  logic [11:0] f_prev_sw = '0;

  always @(negedge clk) begin
    if (rst) begin
      f_prev_l  = 1'b0;
      f_prev_d  = 1'b0;
      f_prev_sw = f_sw[11:0];
      f_stable  = 0;
    end else begin
      if (f_sw[11:0] != f_prev_sw) f_stable = 1; else f_stable++;
      if (f_load_pc_btn || f_deposit_btn) checkOutput("f_btn_overlap", 32'(f_load_pc_btn & f_deposit_btn), 0);
      if ((f_load_pc_btn && !f_prev_l) || (f_deposit_btn && !f_prev_d)) begin
        checkOutput("f_btn_expected", 32'(fq.size() != 0), 1);
        if (fq.size() != 0) begin
          fe = fq.pop_front();
          checkOutput("f_btn_kind", f_deposit_btn ? 2 : 1, fe.kind);
          checkOutput("f_btn_sw", 32'(f_sw[11:0]), 32'(fe.swv));
          checkOutput("f_setup_cycles", f_stable, 2);
          if (fe.interval != 0) checkOutput("f_rise_interval", cyc - f_last_rise, fe.interval);
        end
        f_last_rise = cyc;
        f_rise_cyc  = cyc;
      end
      if ((f_prev_l && !f_load_pc_btn) || (f_prev_d && !f_deposit_btn)) checkOutput("f_pulse_width", cyc - f_rise_cyc, 1);
      if (f_w_valid && f_w_ready) begin
        if (f_period_expect != 0) checkOutput("f_word_period", cyc - f_last_hs, f_period_expect);
        f_last_hs = cyc;
      end
      f_prev_l  = f_load_pc_btn;
      f_prev_d  = f_deposit_btn;
      f_prev_sw = f_sw[11:0];
    end
  end

  task automatic startLoad();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offers one word once the sequencer is in GET (after pre_gap stall cycles).
  task automatic applyStimulus(input logic [11:0] addr, input logic [11:0] data, input logic last,
                               input int pre_gap, input int a_int, input int period);
    int guard = 0;
    while (!w_ready && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("get_reached", 32'(w_ready), 1);
    repeat (pre_gap) begin
      @(posedge clk); #1;
    end
    if (pre_gap > 0) checkOutput("get_stall_hold", 32'({w_ready, busy}), 32'b11);
    q.push_back('{kind: 1, swv: addr, interval: a_int});
    q.push_back('{kind: 2, swv: data, interval: PULSE + GAP + SETUP});
    if (last) q.push_back('{kind: 1, swv: PC, interval: PULSE + GAP + SETUP});
    period_expect = period;
    w_valid = 1'b1;
    w_addr  = addr;
    w_data  = data;
    w_last  = last;
    @(posedge clk); #1;
    w_valid = 1'b0;
    w_last  = 1'b0;
  endtask

  task automatic runPhase();
    int guard = 0;
    while (!sw[12] && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("run_switch", 32'(sw[12]), 1);
    repeat (40) begin
      @(posedge clk); #1;
    end
    checkOutput("run_wait_low", 32'({busy, sw[12], done}), 32'b110);
    run_led = 1'b1;
    repeat (160) begin
      @(posedge clk); #1;
    end
    checkOutput("run_wait_high", 32'({busy, sw[12], done}), 32'b110);
    run_led = 1'b0;
    checkOutput("done_early", 32'(done), 0);
    @(posedge clk); #1;
    checkOutput("done_pulse", 32'({done, sw}), 32'({1'b1, 1'b0, PC}));
    @(posedge clk); #1;
    checkOutput("done_clear", 32'({done, busy, sw}), 0);
  endtask

  task automatic fastTest();
    int guard = 0;
    @(posedge clk); #1 f_start = 1'b1;
    @(posedge clk); #1 f_start = 1'b0;
    fq.push_back('{kind: 1, swv: 12'o0101, interval: 0});
    fq.push_back('{kind: 2, swv: 12'o0202, interval: 3});
    fq.push_back('{kind: 1, swv: 12'o0303, interval: 4});
    fq.push_back('{kind: 2, swv: 12'o0404, interval: 3});
    fq.push_back('{kind: 1, swv: PC,       interval: 3});
    checkOutput("f_get_first", 32'(f_w_ready), 1);
    f_period_expect = 0;
    f_w_valid = 1'b1; f_w_addr = 12'o0101; f_w_data = 12'o0202; f_w_last = 1'b0;
    @(posedge clk); #1;
    f_w_valid = 1'b0;
    while (!f_w_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    f_period_expect = 7;
    f_w_valid = 1'b1; f_w_addr = 12'o0303; f_w_data = 12'o0404; f_w_last = 1'b1;
    @(posedge clk); #1;
    f_w_valid = 1'b0; f_w_last = 1'b0;
    guard = 0;
    while (!f_sw[12] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("f_run_switch", 32'(f_sw[12]), 1);
    f_run_led = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    f_run_led = 1'b0;
    checkOutput("f_done_early", 32'(f_done), 0);
    @(posedge clk); #1;
    checkOutput("f_done_pulse", 32'({f_done, f_sw}), 32'({1'b1, 1'b0, PC}));
    @(posedge clk); #1;
    checkOutput("f_done_clear", 32'({f_done, f_busy}), 0);
    checkOutput("f_queue_empty", fq.size(), 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    start = 1'b0; w_valid = 1'b0; w_addr = '0; w_data = '0; w_last = 1'b0; run_led = 1'b0;
    f_start = 1'b0; f_w_valid = 1'b0; f_w_addr = '0; f_w_data = '0; f_w_last = 1'b0; f_run_led = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sw", 32'(sw), 0);
    checkOutput("reset_buttons", 32'({load_pc_btn, deposit_btn}), 0);
    checkOutput("reset_flags", 32'({w_ready, busy, done}), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("idle_no_start", 32'({w_ready, busy}), 0);

    fastTest();

    // One-word image followed by the run/halt handshake.
    startLoad();
    applyStimulus(12'o0200, 12'o7402, 1'b1, 0, 0, 0);
    runPhase();

    // Three words with GET stalls; a stray start lands in A_GAP of word two.
    startLoad();
    applyStimulus(12'o0017, 12'o1234, 1'b0, 0, 0, 0);
    applyStimulus(12'o0020, 12'o4321, 1'b0, 5, 0, 0);
    repeat (25) begin
      @(posedge clk); #1;
    end
    checkOutput("start_in_gap_state", 32'({busy, load_pc_btn, deposit_btn, w_ready}), 32'b1000);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    applyStimulus(12'o0021, 12'o7777, 1'b1, 5, 0, 0);
    runPhase();

    // Back-to-back words, then reset while the second is being deposited.
    startLoad();
    applyStimulus(12'o0300, 12'o0055, 1'b0, 0, 0, 0);
    applyStimulus(12'o0301, 12'o0066, 1'b0, 0, PULSE + GAP + 1 + SETUP, 1 + 2 * (SETUP + PULSE + GAP));
    guard = 0;
    while (!deposit_btn && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("reached_d_pul", 32'(deposit_btn), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_buttons", 32'({load_pc_btn, deposit_btn}), 0);
    checkOutput("rst_mid_sw", 32'(sw), 0);
    checkOutput("rst_mid_flags", 32'({w_ready, busy, done}), 0);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("after_rst_idle", 32'({busy, load_pc_btn, deposit_btn}), 0);
    checkOutput("words_consumed", hs_count, 6);
    checkOutput("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    tests++;
    failed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
